// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// Module : branch_pkg
// Brief  : Shared branch-prediction types: predictor counter state, queue entry.
// Rev    : 1.0 - initial release
// ============================================================================
package branch_pkg;

    localparam int          BPQ_BHT_BITS              = 3;
    localparam int          BPQ_PHT_BITS              = 7;
    localparam logic [31:0] DEFAULT_DELAY_SLOT_OFFSET = 32'd8;

    typedef enum logic [1:0] {
        STRONG_NOT_TAKEN = 2'b00,
        WEAK_NOT_TAKEN   = 2'b01,
        WEAK_TAKEN       = 2'b10,
        STRONG_TAKEN     = 2'b11
    } predict_state_t;

    typedef struct packed {
        logic [31:0]             pc;
        logic [BPQ_BHT_BITS-1:0] bht_index;
        logic [BPQ_PHT_BITS-1:0] pht_index;
        logic                    pred_taken;
        logic [31:0]             pred_target;
    } bpq_entry_t;

endpackage
`default_nettype wire

// File: rtl/bpq_storage.sv
`default_nettype none
// ============================================================================
// Module : bpq_storage
// Brief  : DEPTH-entry register array, write at tail, combinational read at head.
// Rev    : 1.0 - initial release
// ============================================================================
module bpq_storage
    import branch_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int PTR_BITS = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [PTR_BITS-1:0] wr_ptr,
    input  bpq_entry_t          wr_data,
    input  logic [PTR_BITS-1:0] rd_ptr,
    output bpq_entry_t          rd_data
);

    // Payload only; occupancy lives in the top, so no reset is needed here.
    bpq_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/branch_resolve_queue.sv
`default_nettype none
// ============================================================================
// Module : branch_resolve_queue
// Brief  : In-order queue of predicted branches; trains predictor, flags redirects.
// Rev    : 1.0 - initial release
// ============================================================================
module branch_resolve_queue
    import branch_pkg::*;
#(
    parameter int          DEPTH             = 4,
    parameter int          BHT_INDEX_BITS    = 3,
    parameter int          PHT_INDEX_BITS    = 7,
    parameter logic [31:0] DELAY_SLOT_OFFSET = DEFAULT_DELAY_SLOT_OFFSET
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    input  logic [31:0]                enq_pc,
    input  logic [BHT_INDEX_BITS-1:0]  enq_bht_index,
    input  logic [PHT_INDEX_BITS-1:0]  enq_pht_index,
    input  logic                       enq_pred_taken,
    input  logic [31:0]                enq_pred_target,
    input  logic                       res_valid,
    input  logic                       res_taken,
    input  logic [31:0]                res_target,
    output logic                       upd_valid,
    output logic [BHT_INDEX_BITS-1:0]  upd_bht_index,
    output logic [PHT_INDEX_BITS-1:0]  upd_pht_index,
    output logic                       upd_taken,
    output logic                       mispredict,
    output logic [31:0]                redirect_pc,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       underflow_err
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;
    localparam logic [CNT_BITS-1:0] FULL_COUNT = CNT_BITS'(DEPTH);

    // The entry struct has fixed field widths, so the index parameters must match it.
    generate
        if (BHT_INDEX_BITS != BPQ_BHT_BITS || PHT_INDEX_BITS != BPQ_PHT_BITS ||
            DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
            $error("branch_resolve_queue: unsupported parameter combination");
        end
    endgenerate

    logic [PTR_BITS-1:0] head;
    logic [PTR_BITS-1:0] tail;
    logic [CNT_BITS-1:0] next_count;
    bpq_entry_t          enq_entry;
    bpq_entry_t          head_entry;
    logic                empty;
    logic                pop;
    logic                push;
    logic                dir_miss;
    logic                tgt_miss;
    logic                miss;
    logic                flush;

    assign empty     = (count == '0);
    assign enq_ready = (count != FULL_COUNT);

    assign dir_miss = head_entry.pred_taken != res_taken;
    assign tgt_miss = head_entry.pred_taken && res_taken &&
                      (head_entry.pred_target != res_target);
    assign miss     = dir_miss || tgt_miss;

    assign pop   = res_valid && !empty;
    assign flush = pop && miss;
    // A pop in the same cycle frees the head slot, so a full queue may still accept.
    assign push  = enq_valid && (enq_ready || pop) && !flush;

    assign enq_entry = '{
        pc:          enq_pc,
        bht_index:   enq_bht_index,
        pht_index:   enq_pht_index,
        pred_taken:  enq_pred_taken,
        pred_target: enq_pred_target
    };

    bpq_storage #(
        .DEPTH    (DEPTH),
        .PTR_BITS (PTR_BITS)
    ) u_storage (
        .clk     (clk),
        .wr_en   (push),
        .wr_ptr  (tail),
        .wr_data (enq_entry),
        .rd_ptr  (head),
        .rd_data (head_entry)
    );

    always_comb begin
        next_count = count;
        case ({push, pop})
            2'b10:   next_count = count + CNT_BITS'(1);
            2'b01:   next_count = count - CNT_BITS'(1);
            default: next_count = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            underflow_err <= 1'b0;
        end else begin
            if (flush) begin
                head  <= tail;
                count <= '0;
            end else begin
                if (push) tail <= tail + PTR_BITS'(1);
                if (pop)  head <= head + PTR_BITS'(1);
                count <= next_count;
            end
            if (res_valid && empty) underflow_err <= 1'b1;
        end
    end

    // Resolution results are single-cycle pulses; idle cycles drive zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            upd_valid     <= 1'b0;
            upd_bht_index <= '0;
            upd_pht_index <= '0;
            upd_taken     <= 1'b0;
            mispredict    <= 1'b0;
            redirect_pc   <= '0;
        end else begin
            upd_valid     <= pop;
            upd_bht_index <= pop ? head_entry.bht_index : '0;
            upd_pht_index <= pop ? head_entry.pht_index : '0;
            upd_taken     <= pop && res_taken;
            mispredict    <= flush;
            if (!pop)
                redirect_pc <= '0;
            else if (res_taken)
                redirect_pc <= res_target;
            else
                redirect_pc <= head_entry.pc + DELAY_SLOT_OFFSET;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_queue.sv
`default_nettype none
// ============================================================================
// Module : tb_branch_resolve_queue
// Brief  : Directed self-checking bench for branch_resolve_queue.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        enq_valid;
    logic        enq_ready;
    logic [31:0] enq_pc;
    logic [2:0]  enq_bht_index;
    logic [6:0]  enq_pht_index;
    logic        enq_pred_taken;
    logic [31:0] enq_pred_target;
    logic        res_valid;
    logic        res_taken;
    logic [31:0] res_target;
    logic        upd_valid;
    logic [2:0]  upd_bht_index;
    logic [6:0]  upd_pht_index;
    logic        upd_taken;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [2:0]  count;
    logic        underflow_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_resolve_queue #(
        .DEPTH             (4),
        .BHT_INDEX_BITS    (3),
        .PHT_INDEX_BITS    (7),
        .DELAY_SLOT_OFFSET (32'd8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .enq_valid       (enq_valid),
        .enq_ready       (enq_ready),
        .enq_pc          (enq_pc),
        .enq_bht_index   (enq_bht_index),
        .enq_pht_index   (enq_pht_index),
        .enq_pred_taken  (enq_pred_taken),
        .enq_pred_target (enq_pred_target),
        .res_valid       (res_valid),
        .res_taken       (res_taken),
        .res_target      (res_target),
        .upd_valid       (upd_valid),
        .upd_bht_index   (upd_bht_index),
        .upd_pht_index   (upd_pht_index),
        .upd_taken       (upd_taken),
        .mispredict      (mispredict),
        .redirect_pc     (redirect_pc),
        .count           (count),
        .underflow_err   (underflow_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_enq(input logic [31:0] pc, input logic [2:0] b, input logic [6:0] p,
                           input logic pt, input logic [31:0] tg);
        enq_valid = 1'b1; enq_pc = pc; enq_bht_index = b; enq_pht_index = p;
        enq_pred_taken = pt; enq_pred_target = tg;
    endtask

    task automatic enq_one(input logic [31:0] pc, input logic [2:0] b, input logic [6:0] p,
                           input logic pt, input logic [31:0] tg);
        set_enq(pc, b, p, pt, tg);
        step();
        enq_valid = 1'b0;
    endtask

    task automatic resolve(input logic tk, input logic [31:0] tg);
        res_valid = 1'b1; res_taken = tk; res_target = tg;
        step();
        res_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL reset_enq_ready got %0b exp 1", enq_ready); end
        checks++; if (upd_valid !== 1'b0 || mispredict !== 1'b0) begin errors++; $display("FAIL reset_pulses upd %0b mis %0b exp 0 0", upd_valid, mispredict); end
        checks++; if (redirect_pc !== 32'h0 || underflow_err !== 1'b0) begin errors++; $display("FAIL reset_misc pc %0h uf %0b exp 0 0", redirect_pc, underflow_err); end
    endtask

    task automatic test_correct_not_taken();
        enq_one(32'h100, 3'd3, 7'h15, 1'b0, 32'h0);
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL nt_count_after_enq got %0d exp 1", count); end
        resolve(1'b0, 32'h0);
        checks++; if (upd_valid !== 1'b1) begin errors++; $display("FAIL nt_upd_valid got %0b exp 1", upd_valid); end
        checks++; if (upd_bht_index !== 3'd3 || upd_pht_index !== 7'h15) begin errors++; $display("FAIL nt_indices got %0h/%0h exp 3/15", upd_bht_index, upd_pht_index); end
        checks++; if (upd_taken !== 1'b0 || mispredict !== 1'b0) begin errors++; $display("FAIL nt_taken_mis got %0b/%0b exp 0/0", upd_taken, mispredict); end
        checks++; if (redirect_pc !== 32'h108) begin errors++; $display("FAIL nt_redirect got %0h exp 108", redirect_pc); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL nt_count got %0d exp 0", count); end
        step();
        checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL nt_pulse_end got %0b exp 0", upd_valid); end
    endtask

    task automatic test_dir_miss();
        enq_one(32'h200, 3'd1, 7'h22, 1'b1, 32'h400);
        resolve(1'b0, 32'h0);
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL dir_mispredict got %0b exp 1", mispredict); end
        checks++; if (redirect_pc !== 32'h208) begin errors++; $display("FAIL dir_redirect got %0h exp 208", redirect_pc); end
        checks++; if (upd_taken !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL dir_taken_count got %0b/%0d exp 0/0", upd_taken, count); end
        step();
        checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL dir_pulse_end got %0b exp 0", mispredict); end
    endtask

    task automatic test_tgt_miss();
        enq_one(32'h300, 3'd2, 7'h33, 1'b1, 32'h500);
        resolve(1'b1, 32'h600);
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL tgt_mispredict got %0b exp 1", mispredict); end
        checks++; if (redirect_pc !== 32'h600) begin errors++; $display("FAIL tgt_redirect got %0h exp 600", redirect_pc); end
        checks++; if (upd_taken !== 1'b1) begin errors++; $display("FAIL tgt_upd_taken got %0b exp 1", upd_taken); end
        step();
    endtask

    task automatic test_full_and_simultaneous();
        logic [2:0]  eb [4];
        logic [6:0]  ep [4];
        logic [31:0] er [4];
        for (int i = 0; i < 4; i++) begin
            enq_one(32'h1000 + 32'(i) * 32'h10, 3'(i), 7'h40 + 7'(i), 1'b0, 32'h0);
        end
        checks++; if (count !== 3'd4 || enq_ready !== 1'b0) begin errors++; $display("FAIL full_state count %0d ready %0b exp 4 0", count, enq_ready); end
        enq_one(32'h1099, 3'd7, 7'h7f, 1'b0, 32'h0);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_reject count got %0d exp 4", count); end
        set_enq(32'h1040, 3'd5, 7'h50, 1'b0, 32'h0);
        resolve(1'b0, 32'h0);
        enq_valid = 1'b0;
        checks++; if (upd_valid !== 1'b1 || upd_bht_index !== 3'd0 || upd_pht_index !== 7'h40) begin errors++; $display("FAIL simul_head got v%0b %0h/%0h exp v1 0/40", upd_valid, upd_bht_index, upd_pht_index); end
        checks++; if (count !== 3'd4 || mispredict !== 1'b0) begin errors++; $display("FAIL simul_count got %0d mis %0b exp 4 0", count, mispredict); end
        eb[0] = 3'd1; eb[1] = 3'd2; eb[2] = 3'd3; eb[3] = 3'd5;
        ep[0] = 7'h41; ep[1] = 7'h42; ep[2] = 7'h43; ep[3] = 7'h50;
        er[0] = 32'h1018; er[1] = 32'h1028; er[2] = 32'h1038; er[3] = 32'h1048;
        res_valid = 1'b1; res_taken = 1'b0; res_target = 32'h0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (upd_valid !== 1'b1 || upd_bht_index !== eb[i] || upd_pht_index !== ep[i]) begin errors++; $display("FAIL fifo_order[%0d] got v%0b %0h/%0h exp v1 %0h/%0h", i, upd_valid, upd_bht_index, upd_pht_index, eb[i], ep[i]); end
            checks++; if (redirect_pc !== er[i] || count !== 3'(3 - i)) begin errors++; $display("FAIL fifo_pc_count[%0d] got %0h/%0d exp %0h/%0d", i, redirect_pc, count, er[i], 3 - i); end
        end
        res_valid = 1'b0;
        step();
        checks++; if (upd_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL fifo_drained got v%0b count %0d exp 0 0", upd_valid, count); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            enq_one(32'h2000 + 32'(i) * 32'h10, 3'(i + 1), 7'h60 + 7'(i), 1'b0, 32'h0);
        end
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_prefill got %0d exp 3", count); end
        set_enq(32'h2030, 3'd4, 7'h63, 1'b0, 32'h0);
        resolve(1'b1, 32'h3000);
        enq_valid = 1'b0;
        checks++; if (mispredict !== 1'b1 || redirect_pc !== 32'h3000) begin errors++; $display("FAIL flush_redirect got %0b/%0h exp 1/3000", mispredict, redirect_pc); end
        checks++; if (upd_bht_index !== 3'd1 || upd_taken !== 1'b1) begin errors++; $display("FAIL flush_update got %0h/%0b exp 1/1", upd_bht_index, upd_taken); end
        checks++; if (count !== 3'd0 || enq_ready !== 1'b1) begin errors++; $display("FAIL flush_count got %0d ready %0b exp 0 1", count, enq_ready); end
        step();
        checks++; if (upd_valid !== 1'b0 || mispredict !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL flush_quiet got v%0b m%0b c%0d exp 0 0 0", upd_valid, mispredict, count); end
        enq_one(32'h4000, 3'd6, 7'h66, 1'b1, 32'h4400);
        resolve(1'b1, 32'h4400);
        checks++; if (upd_bht_index !== 3'd6 || upd_pht_index !== 7'h66 || mispredict !== 1'b0) begin errors++; $display("FAIL post_flush_entry got %0h/%0h m%0b exp 6/66 m0", upd_bht_index, upd_pht_index, mispredict); end
        checks++; if (redirect_pc !== 32'h4400 || count !== 3'd0) begin errors++; $display("FAIL post_flush_pc got %0h c%0d exp 4400 c0", redirect_pc, count); end
        step();
    endtask

    task automatic test_underflow();
        resolve(1'b1, 32'h5000);
        checks++; if (upd_valid !== 1'b0 || mispredict !== 1'b0) begin errors++; $display("FAIL underflow_no_out got v%0b m%0b exp 0 0", upd_valid, mispredict); end
        checks++; if (underflow_err !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL underflow_flag got %0b c%0d exp 1 c0", underflow_err, count); end
        step(); step(); step();
        checks++; if (underflow_err !== 1'b1) begin errors++; $display("FAIL underflow_sticky got %0b exp 1", underflow_err); end
    endtask

    task automatic test_reset_mid();
        enq_one(32'h6000, 3'd1, 7'h11, 1'b0, 32'h0);
        enq_one(32'h6010, 3'd2, 7'h12, 1'b0, 32'h0);
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL midrst_prefill got %0d exp 2", count); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (count !== 3'd0 || enq_ready !== 1'b1) begin errors++; $display("FAIL midrst_count got %0d ready %0b exp 0 1", count, enq_ready); end
        checks++; if (upd_valid !== 1'b0 || mispredict !== 1'b0 || redirect_pc !== 32'h0) begin errors++; $display("FAIL midrst_outputs got v%0b m%0b pc %0h exp 0 0 0", upd_valid, mispredict, redirect_pc); end
        checks++; if (underflow_err !== 1'b0) begin errors++; $display("FAIL midrst_underflow got %0b exp 0", underflow_err); end
        resolve(1'b0, 32'h0);
        checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL midrst_dropped got %0b exp 0", upd_valid); end
    endtask

    initial begin
        rst = 1'b1;
        enq_valid = 1'b0; enq_pc = '0; enq_bht_index = '0; enq_pht_index = '0;
        enq_pred_taken = 1'b0; enq_pred_target = '0;
        res_valid = 1'b0; res_taken = 1'b0; res_target = '0;
        test_reset();
        test_correct_not_taken();
        test_dir_miss();
        test_tgt_miss();
        test_full_and_simultaneous();
        test_flush();
        test_underflow();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
In-order queue of in-flight predicted branches. Enqueued at Fetch with the predictor's indices and guess; dequeued at branch resolution in Memory.
- Compares the guess against the actual outcome.
- Drives the predictor training interface (update valid, BHT index, PHT index, taken).
- Issues a registered mispredict/redirect to the front end and discards all younger entries.

Parameters:
DEPTH, 4, queue entries (power of 2, >=2)
BHT_INDEX_BITS, 3, BHT index width
PHT_INDEX_BITS, 7, PHT index width
DELAY_SLOT_OFFSET, 8, fall-through offset for not-taken redirect (branch + delay slot)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
enq_valid  in  1  Fetch presents a branch entry
enq_ready  out  1  queue can accept (not full)
enq_pc  in  32  branch PC
enq_bht_index  in  BHT_INDEX_BITS  BHT index used at Fetch
enq_pht_index  in  PHT_INDEX_BITS  PHT index used at Fetch
enq_pred_taken  in  1  predicted direction
enq_pred_target  in  32  predicted target (valid when pred_taken)
res_valid  in  1  oldest branch resolved this cycle
res_taken  in  1  actual direction
res_target  in  32  actual taken target
upd_valid  out  1  train predictor (branchM)
upd_bht_index  out  BHT_INDEX_BITS  BHT index to train
upd_pht_index  out  PHT_INDEX_BITS  PHT index to train
upd_taken  out  1  actual direction (takenM)
mispredict  out  1  one-cycle redirect pulse
redirect_pc  out  32  correct fetch PC, valid with mispredict
count  out  $clog2(DEPTH)+1  occupancy
underflow_err  out  1  sticky: res_valid while empty

Behaviour:
- Reset: all outputs 0, head = tail = 0, count = 0, enq_ready = 1, underflow_err cleared. Reset mid-operation drops every entry with no update or redirect emitted.
- Enqueue: accept when enq_valid && enq_ready. Entry = {pc, bht_index, pht_index, pred_taken, pred_target}. enq_ready = (count != DEPTH); it is combinational from count only.
- Resolve: when res_valid && count != 0, pop the head entry. Mismatch is computed on it as follows:
  - dir_miss = pred_taken != res_taken
  - tgt_miss = pred_taken && res_taken && (pred_target != res_target)
  - miss = dir_miss || tgt_miss
- Registered outputs, valid the cycle after res_valid (latency 1):
  - upd_valid = 1; upd_bht_index and upd_pht_index from the entry; upd_taken = res_taken.
  - mispredict = miss.
  - redirect_pc = res_taken ? res_target : entry.pc + DELAY_SLOT_OFFSET (32-bit wrap).
  - All of these outputs are pulses and return to 0 the next cycle unless another resolve occurs.
- On miss, all entries are younger wrong-path branches:
  - the pop cycle sets count to 0 and head = tail;
  - an enqueue in the same cycle is dropped.
- Simultaneous enq and res without miss:
  - both occur; count unchanged;
  - allowed even when full, because the pop frees a slot. enq_ready does not reflect this.
- res_valid with count == 0: ignored, no outputs, underflow_err set until reset.
- Pointers are log2(DEPTH) bits and wrap naturally; count saturates at DEPTH by construction.
- Back-to-back resolves every cycle are supported at full throughput.

Decomposition:
- branch_pkg holds:
  - predict_state_t (moved from the predictor);
  - bpq_entry_t struct;
  - DELAY_SLOT_OFFSET default constant.
- The predictor and this block both import branch_pkg.
- One sub-module: bpq_storage, a DEPTH-entry register array with write port at tail and combinational read at head. Flush and pointer logic stay in the top.

Test Plan:
- Reset then enq pc=0x100, pred_taken=0, bht=3, pht=0x15; next cycle res taken=0 -> next cycle upd_valid=1, bht=3, pht=0x15, upd_taken=0, mispredict=0, count=0.
- Enq pc=0x200, pred_taken=1, target=0x400; res taken=0 -> mispredict=1, redirect_pc=0x208.
- Enq pc=0x300, pred_taken=1, target=0x500; res taken=1, target=0x600 -> mispredict=1, redirect_pc=0x600, upd_taken=1.
- Fill 4 entries -> enq_ready=0. Then simultaneous enq + correct res -> count stays 4, new entry is at the tail, and the next 4 resolves return the entries in FIFO order.
- 3 entries queued, oldest mispredicts while enq_valid=1 -> count=0 next cycle, the enqueue is dropped, no further upd_valid for the flushed entries.
- res_valid with empty queue -> no upd_valid, underflow_err=1 and it holds; rst asserted with 2 entries queued -> count=0, no outputs, underflow_err=0.
